// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard/sequencing control.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [5:0] FUNCT_MUL = 6'b000010;
  localparam logic [4:0] REG_ZERO  = 5'd0;

  localparam int MCNT_W = 4;
  localparam int FCNT_W = 3;

  // A load in EX whose destination feeds a source the ID instruction reads.
  function automatic logic load_use_hit(
    input logic       id_valid,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt,
    input logic       ex_mem_read,
    input logic [4:0] ex_rd
  );
    return id_valid & ex_mem_read & (ex_rd != REG_ZERO) &
           ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Free-running wrapping event counter with enable and asynchronous reset.
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: load-use stall, multi-cycle MUL hold in EX, taken-branch
// flush, plus stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LATENCY  = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_mul,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_dm_bubble,
  output logic             if_id_flush,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'(MUL_LATENCY - 1);
  localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);

  state_t              state, state_next;
  logic [MCNT_W-1:0]   mcnt, mcnt_next;
  logic [FCNT_W-1:0]   fcnt, fcnt_next;
  logic                load_use;
  logic                flush_accept;

  assign load_use     = load_use_hit(id_valid, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd);
  assign flush_accept = (state == RUN) & branch_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      mcnt  <= '0;
      fcnt  <= '0;
    end else begin
      state <= state_next;
      mcnt  <= mcnt_next;
      fcnt  <= fcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    mcnt_next  = mcnt;
    fcnt_next  = fcnt;
    case (state)
      RUN: begin
        // A taken branch squashes the ID instruction, so its hazards are moot.
        if (branch_taken) begin
          if (FLUSH_CYCLES > 1) begin
            state_next = FLUSH;
            fcnt_next  = FCNT_INIT;
          end
        end else if (load_use) begin
          state_next = RUN;
        end else if (id_valid && id_is_mul && (MUL_LATENCY > 1)) begin
          state_next = MUL_BUSY;
          mcnt_next  = MCNT_INIT;
        end
      end
      MUL_BUSY: begin
        mcnt_next = mcnt - 1'b1;
        if (mcnt <= MCNT_W'(1))
          state_next = RUN;
      end
      FLUSH: begin
        fcnt_next = fcnt - 1'b1;
        if (fcnt <= FCNT_W'(1))
          state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    ex_dm_bubble = 1'b0;
    if_id_flush  = 1'b0;
    mul_busy     = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      MUL_BUSY: begin
        // Hold the MUL in EX and keep its partial result out of EX/DM.
        mul_busy     = 1'b1;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_dm_bubble = 1'b1;
      end
      FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (~pc_write),
    .count (stall_cycles)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush_accept),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: table of single-cycle RUN vectors plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rt, id_is_mul, ex_mem_read, branch_taken;
  logic [4:0] id_rs, id_rt, ex_rd;

  logic        a_pc_write, a_if_id_write, a_id_ex_write, a_id_ex_bubble;
  logic        a_ex_dm_bubble, a_if_id_flush, a_mul_busy;
  logic [31:0] a_stall_cycles, a_flush_events;

  logic        b_pc_write, b_if_id_write, b_id_ex_write, b_id_ex_bubble;
  logic        b_ex_dm_bubble, b_if_id_flush, b_mul_busy;
  logic [3:0]  b_stall_cycles, b_flush_events;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_LATENCY(3), .FLUSH_CYCLES(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_is_mul(id_is_mul), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .branch_taken(branch_taken), .pc_write(a_pc_write),
    .if_id_write(a_if_id_write), .id_ex_write(a_id_ex_write),
    .id_ex_bubble(a_id_ex_bubble), .ex_dm_bubble(a_ex_dm_bubble),
    .if_id_flush(a_if_id_flush), .mul_busy(a_mul_busy),
    .stall_cycles(a_stall_cycles), .flush_events(a_flush_events)
  );

  pipeline_hazard_ctrl #(.MUL_LATENCY(3), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_is_mul(id_is_mul), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .branch_taken(branch_taken), .pc_write(b_pc_write),
    .if_id_write(b_if_id_write), .id_ex_write(b_id_ex_write),
    .id_ex_bubble(b_id_ex_bubble), .ex_dm_bubble(b_ex_dm_bubble),
    .if_id_flush(b_if_id_flush), .mul_busy(b_mul_busy),
    .stall_cycles(b_stall_cycles), .flush_events(b_flush_events)
  );

  // Output packing: {pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_dm_bubble, if_id_flush, mul_busy}
  localparam logic [6:0] O_NORM  = 7'b1110000;
  localparam logic [6:0] O_STALL = 7'b0011000;
  localparam logic [6:0] O_MUL   = 7'b0000101;
  localparam logic [6:0] O_FLUSH = 7'b1111010;

  function automatic logic [6:0] a_outs();
    return {a_pc_write, a_if_id_write, a_id_ex_write, a_id_ex_bubble,
            a_ex_dm_bubble, a_if_id_flush, a_mul_busy};
  endfunction

  function automatic logic [6:0] b_outs();
    return {b_pc_write, b_if_id_write, b_id_ex_write, b_id_ex_bubble,
            b_ex_dm_bubble, b_if_id_flush, b_mul_busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_is_mul = 0;
    ex_mem_read = 0; ex_rd = 0; branch_taken = 0;
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic mul, input logic mr,
                        input logic [4:0] rd, input logic br);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_is_mul = mul;
    ex_mem_read = mr; ex_rd = rd; branch_taken = br;
  endtask

  // Move to 1 ns after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    idle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       mul;
    logic       mr;
    logic [4:0] rd;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [9];
  int   exp_stalls;

  initial begin
    tbl[0] = '{1, 5'd3,  5'd0,  0, 0, 1, 5'd3,  O_STALL}; // LW $3 feeds rs
    tbl[1] = '{1, 5'd3,  5'd0,  0, 0, 0, 5'd3,  O_NORM};  // stall cleared next cycle
    tbl[2] = '{0, 5'd3,  5'd0,  0, 0, 1, 5'd3,  O_NORM};  // ID empty
    tbl[3] = '{1, 5'd1,  5'd5,  1, 0, 1, 5'd5,  O_STALL}; // rt match, rt read
    tbl[4] = '{1, 5'd1,  5'd5,  0, 0, 1, 5'd5,  O_NORM};  // rt match, rt not read
    tbl[5] = '{1, 5'd0,  5'd0,  1, 0, 1, 5'd0,  O_NORM};  // LW $0 never stalls
    tbl[6] = '{1, 5'd6,  5'd8,  1, 0, 1, 5'd7,  O_NORM};  // no register match
    tbl[7] = '{1, 5'd31, 5'd2,  0, 0, 1, 5'd31, O_STALL}; // top register
    tbl[8] = '{0, 5'd2,  5'd3,  1, 1, 0, 5'd9,  O_NORM};  // MUL flag without valid

    idle();
    reset = 1'b1;
    #2;
    check("reset_outs_a", 32'(a_outs()), 32'(O_NORM));
    check("reset_outs_b", 32'(b_outs()), 32'(O_NORM));
    check("reset_stall_cnt", a_stall_cycles, 32'd0);
    check("reset_flush_cnt", a_flush_events, 32'd0);
    #5;
    reset = 1'b0;

    // Single-cycle RUN vectors
    exp_stalls = 0;
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      set_in(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urt, tbl[i].mul,
             tbl[i].mr, tbl[i].rd, 1'b0);
      #1;
      check($sformatf("vec%0d_outs", i), 32'(a_outs()), 32'(tbl[i].exp));
      if (tbl[i].exp[6] == 1'b0) exp_stalls++;
    end
    next_cycle();
    idle();
    check("vec_stall_cnt", a_stall_cycles, 32'(exp_stalls));

    // MUL enters EX, held 2 busy cycles, result released on the third
    do_reset();
    set_in(1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0);
    #1;
    check("mul_issue_outs", 32'(a_outs()), 32'(O_NORM));
    next_cycle();
    idle();
    #1;
    check("mul_busy1_outs", 32'(a_outs()), 32'(O_MUL));
    next_cycle();
    check("mul_busy2_outs", 32'(a_outs()), 32'(O_MUL));
    next_cycle();
    check("mul_done_outs", 32'(a_outs()), 32'(O_NORM));
    check("mul_stall_cnt", a_stall_cycles, 32'd2);

    // Taken branch: single-cycle flush on A, three-cycle flush on B
    do_reset();
    set_in(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1);
    #1;
    check("br_outs_a", 32'(a_outs()), 32'(O_FLUSH));
    check("br_outs_b", 32'(b_outs()), 32'(O_FLUSH));
    next_cycle();
    #1;
    check("br_second_a", 32'(a_outs()), 32'(O_FLUSH));
    check("br_flushst_b", 32'(b_outs()), 32'(O_FLUSH));
    next_cycle();
    branch_taken = 0;
    #1;
    check("br_post_a", 32'(a_outs()), 32'(O_NORM));
    check("br_flushst2_b", 32'(b_outs()), 32'(O_FLUSH));
    next_cycle();
    check("br_run_b", 32'(b_outs()), 32'(O_NORM));
    check("br_flush_cnt_a", a_flush_events, 32'd2);
    check("br_flush_cnt_b", 32'(b_flush_events), 32'd1);
    check("br_stall_cnt_a", a_stall_cycles, 32'd0);

    // Branch, load-use and MUL together: flush wins, no stall, no MUL
    do_reset();
    set_in(1, 5'd4, 5'd0, 0, 1, 1, 5'd4, 1);
    #1;
    check("combo_outs", 32'(a_outs()), 32'(O_FLUSH));
    next_cycle();
    idle();
    #1;
    check("combo_next_outs", 32'(a_outs()), 32'(O_NORM));
    check("combo_stall_cnt", a_stall_cycles, 32'd0);
    check("combo_flush_cnt", a_flush_events, 32'd1);

    // Load-use with MUL in ID: stall first, MUL_BUSY one cycle later
    do_reset();
    set_in(1, 5'd4, 5'd0, 0, 1, 1, 5'd4, 0);
    #1;
    check("lumul_stall_outs", 32'(a_outs()), 32'(O_STALL));
    next_cycle();
    set_in(1, 5'd4, 5'd0, 0, 1, 0, 5'd0, 0);
    #1;
    check("lumul_issue_outs", 32'(a_outs()), 32'(O_NORM));
    next_cycle();
    idle();
    #1;
    check("lumul_busy_outs", 32'(a_outs()), 32'(O_MUL));

    // Asynchronous reset during MUL_BUSY
    reset = 1'b1;
    #1;
    check("rst_mid_mul_outs", 32'(a_outs()), 32'(O_NORM));
    check("rst_mid_mul_cnt", a_stall_cycles, 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    check("rst_after_outs", 32'(a_outs()), 32'(O_NORM));
    check("rst_after_cnt", a_stall_cycles, 32'd0);

    // Sixteen stalls wrap the 4-bit counter on B
    do_reset();
    set_in(1, 5'd9, 5'd0, 0, 0, 1, 5'd9, 0);
    for (int i = 0; i < 15; i++) next_cycle();
    check("wrap_cnt15_b", 32'(b_stall_cycles), 32'd15);
    next_cycle();
    idle();
    check("wrap_cnt0_b", 32'(b_stall_cycles), 32'd0);
    check("wrap_cnt16_a", a_stall_cycles, 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
